// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Two-port arbiter/sequencer for the shared data memory. Port 0
//             is the CPU load/store path, port 1 the DMA/debug path. Each
//             access runs IDLE -> ACCESS -> RESP and is answered with a
//             one-cycle ack plus registered read data and range-error flag.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
   parameter int FIXED_PRI      = 0,   // 0 = round-robin, 1 = port 0 wins ties
   parameter int MEM_WORDS_LOG2 = 5    // word-address width of the memory
) (
   input  logic        clk,
   input  logic        clrn,
   // port 0 (CPU)
   input  logic        req0,
   input  logic        we0,
   input  logic [31:0] addr0,
   input  logic [31:0] wdata0,
   output logic        ack0,
   output logic [31:0] rdata0,
   output logic        err0,
   // port 1 (DMA / debug)
   input  logic        req1,
   input  logic        we1,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata1,
   output logic        ack1,
   output logic [31:0] rdata1,
   output logic        err1,
   // memory side
   output logic [31:0] mem_addr,
   output logic [31:0] mem_datain,
   output logic        mem_we,
   input  logic [31:0] mem_dataout,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t      state_q,  state_d;
   logic        owner_q,  owner_d;
   logic        last_q,   last_d;
   logic        ack0_q,   ack0_d;
   logic        ack1_q,   ack1_d;
   logic [31:0] rdata0_q, rdata0_d;
   logic [31:0] rdata1_q, rdata1_d;
   logic        err0_q,   err0_d;
   logic        err1_q,   err1_d;

   logic        w_winner;
   logic        w_owner_we;
   logic [31:0] w_owner_addr;
   logic [31:0] w_owner_wdata;
   logic        w_in_range;

   // Steer the granted requester's inputs and decode whether its address hits the memory
   always_comb begin
      w_owner_we    = owner_q ? we1    : we0;
      w_owner_addr  = owner_q ? addr1  : addr0;
      w_owner_wdata = owner_q ? wdata1 : wdata0;
      w_in_range    = (w_owner_addr[31:MEM_WORDS_LOG2+2] == '0);
   end

   // Pick the winner among current requesters; a tie goes to the port not served last
   always_comb begin
      w_winner = 1'b0;
      if (req0 && req1) begin
         w_winner = (FIXED_PRI != 0) ? 1'b0 : ~last_q;
      end else if (req1) begin
         w_winner = 1'b1;
      end
   end

   // Next-state, memory-side outputs and response capture
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_d     = last_q;
      ack0_d     = 1'b0;
      ack1_d     = 1'b0;
      rdata0_d   = rdata0_q;
      rdata1_d   = rdata1_q;
      err0_d     = err0_q;
      err1_d     = err1_q;
      mem_addr   = '0;
      mem_datain = '0;
      mem_we     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               owner_d = w_winner;
               last_d  = w_winner;
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            mem_addr   = w_owner_addr;
            mem_datain = w_owner_wdata;
            // write is suppressed for out-of-range addresses so no alias gets clobbered
            mem_we     = w_owner_we & w_in_range;
            if (owner_q) begin
               ack1_d   = 1'b1;
               rdata1_d = w_in_range ? mem_dataout : '0;
               err1_d   = ~w_in_range;
            end else begin
               ack0_d   = 1'b1;
               rdata0_d = w_in_range ? mem_dataout : '0;
               err0_d   = ~w_in_range;
            end
            state_d = S_RESP;
         end
         S_RESP: begin
            // ack is visible this cycle; requests are only looked at again in IDLE
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and response registers; last resets to 1 so port 0 wins the first tie
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q  <= S_IDLE;
         owner_q  <= 1'b0;
         last_q   <= 1'b1;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
         err0_q   <= 1'b0;
         err1_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         ack0_q   <= ack0_d;
         ack1_q   <= ack1_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         err0_q   <= err0_d;
         err1_q   <= err1_d;
      end
   end

   assign ack0   = ack0_q;
   assign ack1   = ack1_q;
   assign rdata0 = rdata0_q;
   assign rdata1 = rdata1_q;
   assign err0   = err0_q;
   assign err1   = err1_q;
   assign busy   = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Purpose  : Scoreboard bench for dmem_arbiter with a 32x32 memory model.
//             A second instance with FIXED_PRI=1 shares the request inputs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

   logic        clk;
   logic        clrn;
   logic        req0, we0, req1, we1;
   logic [31:0] addr0, wdata0, addr1, wdata1;
   logic        ack0, err0, ack1, err1;
   logic [31:0] rdata0, rdata1;
   logic [31:0] mem_addr, mem_datain, mem_dataout;
   logic        mem_we, busy;

   // fixed-priority instance outputs
   logic        f_ack0, f_err0, f_ack1, f_err1, f_mem_we, f_busy;
   logic [31:0] f_rdata0, f_rdata1, f_mem_addr, f_mem_datain, f_mem_dataout;

   logic [31:0] mem [0:31];
   logic        mem_init;

   typedef struct {
      bit          port;
      logic [31:0] rd;
      bit          err;
   } exp_t;
   exp_t sb[$];

   int errors = 0;
   int checks = 0;
   int oor_we = 0;
   int fa0 = 0;
   int fa1 = 0;
   logic win;
   int cyc, nack, lastc;

   dmem_arbiter #(.FIXED_PRI(0), .MEM_WORDS_LOG2(5)) u_dut (
      .clk(clk), .clrn(clrn),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .ack0(ack0), .rdata0(rdata0), .err0(err0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .ack1(ack1), .rdata1(rdata1), .err1(err1),
      .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_we(mem_we),
      .mem_dataout(mem_dataout), .busy(busy)
   );

   dmem_arbiter #(.FIXED_PRI(1), .MEM_WORDS_LOG2(5)) u_fix (
      .clk(clk), .clrn(clrn),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .ack0(f_ack0), .rdata0(f_rdata0), .err0(f_err0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .ack1(f_ack1), .rdata1(f_rdata1), .err1(f_err1),
      .mem_addr(f_mem_addr), .mem_datain(f_mem_datain), .mem_we(f_mem_we),
      .mem_dataout(f_mem_dataout), .busy(f_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory model: word i preloads to 0x1000+i, except word 0x15 = 0x27
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 32; i++) mem[i] <= (i == 21) ? 32'h27 : 32'h1000 + i;
      end else if (mem_we) begin
         mem[mem_addr[6:2]] <= mem_datain;
      end
   end
   assign mem_dataout   = mem[mem_addr[6:2]];
   assign f_mem_dataout = mem[f_mem_addr[6:2]];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // scoreboard monitor: every ack pops one expected response
   always @(negedge clk) begin : mon
      exp_t e;
      if (ack0 || ack1) begin
         if (ack0 && ack1) begin
            checks++; errors++;
            $display("FAIL dual_ack: got ack0=1 ack1=1 expected one ack");
         end else if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ack: got ack0=%0d ack1=%0d expected none", ack0, ack1);
         end else begin
            e = sb.pop_front();
            chk("sb_port",  32'(ack1), 32'(e.port));
            chk("sb_rdata", ack1 ? rdata1 : rdata0, e.rd);
            chk("sb_err",   32'(ack1 ? err1 : err0), 32'(e.err));
         end
      end
      if (mem_we && mem_addr[31:7] != 25'd0) oor_we++;
      if (win) begin
         if (f_ack0) fa0++;
         if (f_ack1) fa1++;
      end
   end

   task automatic wait_ack(input bit p, input string name);
      bit got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (p ? ack1 : ack0) got = 1'b1;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s: got no ack%0d expected ack within 10 cycles", name, p);
      end
   endtask

   task automatic txn(input bit p, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input bit exp_err, input string name);
      sb.push_back('{port: p, rd: exp_rd, err: exp_err});
      if (!p) begin we0 = we; addr0 = addr; wdata0 = wd; req0 = 1'b1; end
      else    begin we1 = we; addr1 = addr; wdata1 = wd; req1 = 1'b1; end
      wait_ack(p, name);
      if (!p) req0 = 1'b0; else req1 = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish before 200000");
      $fatal(1);
   end

   initial begin
      clrn = 1'b0; mem_init = 1'b1; win = 1'b0;
      req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
      req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
      repeat (2) @(posedge clk);
      #1 mem_init = 1'b0;
      chk("rst_ack0",   32'(ack0), 0);
      chk("rst_ack1",   32'(ack1), 0);
      chk("rst_rdata0", rdata0, 0);
      chk("rst_rdata1", rdata1, 0);
      chk("rst_err",    32'({err0, err1}), 0);
      chk("rst_busy",   32'(busy), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      @(negedge clk) clrn = 1'b1;
      @(posedge clk); #1;

      // port 0 write, cycle-accurate checks; read data returns the old word
      sb.push_back('{port: 1'b0, rd: 32'h1014, err: 1'b0});
      we0 = 1; addr0 = 32'h50; wdata0 = 32'hDEADBEEF; req0 = 1;
      @(posedge clk); #1;
      chk("wr_busy",     32'(busy), 1);
      chk("wr_mem_we",   32'(mem_we), 1);
      chk("wr_mem_addr", mem_addr, 32'h50);
      chk("wr_mem_din",  mem_datain, 32'hDEADBEEF);
      chk("wr_noack",    32'(ack0), 0);
      @(posedge clk); #1;
      chk("wr_ack0",     32'(ack0), 1);
      chk("wr_resp_we",  32'(mem_we), 0);
      chk("wr_mem20",    mem[20], 32'hDEADBEEF);
      req0 = 0;
      @(posedge clk); #1;
      chk("wr_ack_drop", 32'(ack0), 0);
      chk("wr_idle",     32'(busy), 0);

      // reads, out-of-range write, cross-port write/read
      txn(0, 0, 32'h54, 0, 32'h27, 0, "rd54");
      chk("rd54_rdata1_untouched", rdata1, 0);
      txn(1, 1, 32'h80, 32'hCAFEF00D, 0, 1, "oor80");
      chk("oor_mem0", mem[0], 32'h1000);
      txn(1, 1, 32'h5C, 32'h12345678, 32'h1017, 0, "wr5C");
      txn(0, 0, 32'h5C, 0, 32'h12345678, 0, "rd5C");
      chk("rdata1_hold", rdata1, 32'h1017);
      chk("err1_hold",   32'(err1), 0);
      txn(0, 0, 32'h5F, 0, 32'h12345678, 0, "rd5F");

      // fresh reset, then both ports held: grants must alternate 0,1,0,1
      clrn = 1'b0;
      @(negedge clk) clrn = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++)
         sb.push_back('{port: k[0], rd: k[0] ? 32'h12345678 : 32'h27, err: 1'b0});
      we0 = 0; addr0 = 32'h54; we1 = 0; addr1 = 32'h5C;
      req0 = 1; req1 = 1; win = 1;
      cyc = 0; nack = 0; lastc = -1;
      while (nack < 4 && cyc < 30) begin
         @(negedge clk);
         cyc++;
         if (ack0 || ack1) begin
            nack++;
            if (lastc >= 0) chk("alt_spacing", 32'(cyc - lastc), 3);
            lastc = cyc;
         end
      end
      req0 = 0; req1 = 0;
      chk("alt_count", 32'(nack), 4);
      @(posedge clk); #1;
      win = 0;
      chk("fix_ack0_count", 32'(fa0), 4);
      chk("fix_ack1_count", 32'(fa1), 0);
      chk("fix_rdata0",     f_rdata0, 32'h27);

      // reset in the middle of a write access
      we0 = 1; addr0 = 32'h60; wdata0 = 32'hBADBAD00; req0 = 1;
      we1 = 0; addr1 = 32'h54; req1 = 1;
      @(posedge clk); #1;
      chk("mid_mem_we", 32'(mem_we), 1);
      chk("mid_addr",   mem_addr, 32'h60);
      #1 clrn = 1'b0;
      #1;
      chk("mid_rst_we",   32'(mem_we), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_ack",  32'({ack0, ack1}), 0);
      @(posedge clk); #1;
      chk("mid_rst_mem24", mem[24], 32'h1018);
      sb.push_back('{port: 1'b0, rd: 32'h1018, err: 1'b0});
      sb.push_back('{port: 1'b1, rd: 32'h27,   err: 1'b0});
      @(negedge clk) clrn = 1'b1;
      wait_ack(0, "post_rst_p0");
      req0 = 0;
      wait_ack(1, "post_rst_p1");
      req1 = 0;
      @(posedge clk); #1;
      chk("post_rst_mem24", mem[24], 32'hBADBAD00);
      chk("rdata0_hold",    rdata0, 32'h1018);

      repeat (3) @(posedge clk);
      #1;
      chk("sb_empty",  32'(sb.size()), 0);
      chk("no_oor_we", 32'(oor_we), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter/sequencer for the shared 32-word x 32-bit data memory: combinational read, write on posedge clk when we=1, word index addr[6:2].
- Port 0 is the CPU load/store path; port 1 is the DMA/debug path.
- Serialises accesses through a 3-state FSM with round-robin (or fixed) priority.
- Registers read data and returns a one-cycle ack per transaction.

Parameters:
- FIXED_PRI, 0, 0 = round-robin; 1 = port 0 always wins ties.
- MEM_WORDS_LOG2, 5, word-address width; legal byte range is 0 .. (4<<MEM_WORDS_LOG2)-1.

Ports:
- clk  in  1  system clock, all state on posedge.
- clrn  in  1  asynchronous active-low reset.
- req0  in  1  port 0 request; held with addr0/we0/wdata0 stable until ack0.
- we0  in  1  port 0 write (1) / read (0).
- addr0  in  32  port 0 byte address.
- wdata0  in  32  port 0 write data.
- ack0  out  1  port 0 one-cycle completion pulse.
- rdata0  out  32  port 0 read data, valid while ack0=1.
- err0  out  1  port 0 out-of-range flag, valid while ack0=1.
- req1, we1, addr1, wdata1, ack1, rdata1, err1: same as port 0, for port 1.
- mem_addr  out  32  address to the memory.
- mem_datain  out  32  write data to the memory.
- mem_we  out  1  memory write enable.
- mem_dataout  in  32  combinational read data from the memory.
- busy  out  1  1 when state != IDLE.

Behaviour:
- Reset (clrn=0, async): state=IDLE, owner=0, last=1 (port 0 wins first tie), ack0/ack1=0, rdata0/rdata1=0, err0/err1=0.
- Because mem_we is decoded from state, it drops to 0 immediately on reset; no partial write occurs.
- States:
  - IDLE: mem_we=0, mem_addr=0, mem_datain=0.
    - If req0 or req1, latch owner and go to ACCESS; else stay.
  - ACCESS: mem_addr/mem_datain come from the owner's inputs.
    - mem_we = owner_we AND in_range.
    - At the closing edge: rdata_owner <= in_range ? mem_dataout : 0; err_owner <= ~in_range; ack_owner <= 1; go to RESP.
  - RESP: ack_owner=1 for exactly this cycle; mem_we=0; no arbitration. Next state is IDLE.
- Latency and throughput:
  - req sampled at edge N (state IDLE), ACCESS during cycle N..N+1, ack high during cycle N+1..N+2.
  - Maximum throughput is one transaction per 3 cycles.
- Arbitration (IDLE only):
  - Single request: it wins.
  - Both requesting, FIXED_PRI=0: winner = ~last; last <= winner on entering ACCESS.
  - Both requesting, FIXED_PRI=1: port 0 wins; last is still updated.
- Address range:
  - in_range = (addr[31:MEM_WORDS_LOG2+2] == 0).
  - Out-of-range: no write, rdata=0, err=1.
  - addr[1:0] is ignored (word access).
- Write-then-read of the same word in consecutive transactions returns the new data (write commits at the ACCESS closing edge).
- rdata/err of a port hold their value until that port's next ack; ack of the other port never alters them.
- Requester may keep req high after ack to issue its next transaction. That request is sampled in the following IDLE, so it cannot re-trigger during RESP.
- Request dropped before grant: ignored, no access. Inputs changed during ACCESS: undefined for the requester, but the FSM still completes and acks.

Test Plan:
- Reset then port 0 write addr0=0x50, wdata0=0xDEADBEEF, single req: mem_we=1 only in ACCESS cycle, ack0 pulses 2 cycles after req sampled, err0=0.
- Port 0 read addr0=0x54 with memory word 0x15 = 0x00000027: rdata0=0x00000027 with ack0; ack1 stays 0.
- req0 and req1 held continuously, FIXED_PRI=0: grants alternate 0,1,0,1 at one ack every 3 cycles. With FIXED_PRI=1 only port 0 is served while req0 is held.
- Port 1 write addr1=0x80 (out of range): mem_we stays 0, ack1=1, err1=1, rdata1=0, memory unchanged.
- Port 1 writes 0x12345678 to 0x5C, then port 0 reads 0x5C: rdata0=0x12345678.
- clrn pulsed low mid-ACCESS of a write: mem_we drops immediately, no ack, target word unchanged, busy=0. After release, a pending req restarts from IDLE with port 0 winning the tie.
